// File: rtl/maindec_mc_if.sv
// Control bundle between the multicycle main decoder and the datapath.
// master = the controller (drives the control lines), slave = datapath side.
interface maindec_mc_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       branch_ne;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst,
           memtoreg, regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop,
           illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, branch_ne, iord, memwrite, irwrite, regdst,
           memtoreg, regwrite, alusrca, alusrcb, zeroext, pcsrc, aluop,
           illegal, state
  );
endinterface

// File: rtl/maindec_mc.sv
// Multicycle MIPS main controller: sequences each instruction through
// fetch/decode/execute/memory/writeback. Control lines are registered
// alongside the state (decoded from the next state), except irwrite and the
// FETCH share of pcwrite, which follow mem_ready within the cycle.
module maindec_mc #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EN_BNE        = 1'b1,
  parameter bit EN_ORI        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  maindec_mc_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    ORIEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       fetch;
    logic       pcwrite;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroext;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  // Moore control table; anything not set stays 0 (covers codes 13-15 too).
  function automatic ctl_t decode(state_t s, logic bne);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.fetch = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCH:  begin
        c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.branch = 1'b1; c.branch_ne = bne;
      end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ORIEX:   begin
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b11; c.zeroext = 1'b1;
      end
      IWB:     c.regwrite = 1'b1;
      JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t st, nxt;
  logic   is_bne, nxt_bne, illegal, bad_op, ready;
  ctl_t   ctl;

  assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // Next-state selection; bad_op flags an opcode that decodes to nothing.
  always_comb begin
    nxt     = FETCH;
    nxt_bne = is_bne;
    bad_op  = 1'b0;
    case (st)
      FETCH:   nxt = ready ? DECODE : FETCH;
      DECODE: begin
        nxt_bne = (bus.op == OP_BNE) && EN_BNE;
        if (bus.op == OP_R)                                nxt = EXECUTE;
        else if (bus.op == OP_LW || bus.op == OP_SW)       nxt = MEMADR;
        else if (bus.op == OP_BEQ)                         nxt = BRANCH;
        else if (bus.op == OP_BNE && EN_BNE)               nxt = BRANCH;
        else if (bus.op == OP_ADDI)                        nxt = ADDIEX;
        else if (bus.op == OP_ORI && EN_ORI)               nxt = ORIEX;
        else if (bus.op == OP_J)                           nxt = JUMP;
        else begin
          nxt    = FETCH;
          bad_op = 1'b1;
        end
      end
      MEMADR:  nxt = bus.op[3] ? MEMWR : MEMRD;
      MEMRD:   nxt = ready ? MEMWB : MEMRD;
      MEMWR:   nxt = ready ? FETCH : MEMWR;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = IWB;
      ORIEX:   nxt = IWB;
      default: nxt = FETCH;
    endcase
  end

  // State, BNE qualifier, sticky illegal flag and registered control lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= FETCH;
      is_bne  <= 1'b0;
      illegal <= 1'b0;
      ctl     <= decode(FETCH, 1'b0);
    end else begin
      st      <= nxt;
      is_bne  <= nxt_bne;
      illegal <= illegal | bad_op;
      ctl     <= decode(nxt, nxt_bne);
    end
  end

  // Write strobes are gated by reset so they fall the instant reset asserts.
  assign bus.pcwrite   = reset & (ctl.pcwrite | (ctl.fetch & ready));
  assign bus.irwrite   = reset & ctl.fetch & ready;
  assign bus.memwrite  = reset & ctl.memwrite;
  assign bus.branch    = ctl.branch;
  assign bus.branch_ne = ctl.branch_ne;
  assign bus.iord      = ctl.iord;
  assign bus.regdst    = ctl.regdst;
  assign bus.memtoreg  = ctl.memtoreg;
  assign bus.regwrite  = ctl.regwrite;
  assign bus.alusrca   = ctl.alusrca;
  assign bus.alusrcb   = ctl.alusrcb;
  assign bus.zeroext   = ctl.zeroext;
  assign bus.pcsrc     = ctl.pcsrc;
  assign bus.aluop     = ctl.aluop;
  assign bus.illegal   = illegal;
  assign bus.state     = st;

endmodule

// File: tb/tb_maindec_mc.sv
// Bench for maindec_mc: two instances (full feature set, and one with
// BNE/ORI disabled and the memory handshake ignored). A stimulus process
// walks each instruction's state path and queues the expected control word
// per cycle; a monitor on the falling edge pops and compares.
module tb_maindec_mc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  maindec_mc_if if0 ();
  maindec_mc_if if1 ();

  maindec_mc dut0 (.clk(clk), .reset(reset), .bus(if0));
  maindec_mc #(.MEM_HANDSHAKE(1'b0), .EN_BNE(1'b0), .EN_ORI(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(if1));

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] sig;
  } exp_t;

  exp_t q0[$], q1[$];
  int   checks = 0, errors = 0;
  bit   ill0 = 1'b0, ill1 = 1'b0;

  logic [17:0] act0, act1;
  assign act0 = {if0.pcwrite, if0.branch, if0.branch_ne, if0.iord, if0.memwrite,
                 if0.irwrite, if0.regdst, if0.memtoreg, if0.regwrite, if0.alusrca,
                 if0.alusrcb, if0.zeroext, if0.pcsrc, if0.aluop, if0.illegal};
  assign act1 = {if1.pcwrite, if1.branch, if1.branch_ne, if1.iord, if1.memwrite,
                 if1.irwrite, if1.regdst, if1.memtoreg, if1.regwrite, if1.alusrca,
                 if1.alusrcb, if1.zeroext, if1.pcsrc, if1.aluop, if1.illegal};

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Control word the controller should show in state s.
  function automatic logic [17:0] ref_sig(int s, bit rdy, bit bne, bit ill);
    bit pcw, br, brne, iord, mw, irw, rd, m2r, rw, asa, zx;
    bit [1:0] asb, pcs, aop;
    {pcw, br, brne, iord, mw, irw, rd, m2r, rw, asa, zx} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (s)
      0:  begin asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; brne = bne; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      12: begin asa = 1; asb = 2'b10; aop = 2'b11; zx = 1; end
      default: ;
    endcase
    return {pcw, br, brne, iord, mw, irw, rd, m2r, rw, asa, asb, zx, pcs, aop, ill};
  endfunction

  // One cycle: drive inputs for the current state, queue its expectation.
  task automatic step(int sel, logic [5:0] op, bit mr, int s, bit bne);
    exp_t e;
    e.st = s[3:0];
    if (sel == 0) begin
      if0.op = op; if0.mem_ready = mr;
      e.sig = ref_sig(s, mr, bne, ill0);
      q0.push_back(e);
    end else begin
      if1.op = op; if1.mem_ready = mr;
      e.sig = ref_sig(s, 1'b1, bne, ill1);
      q1.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Whole instruction from FETCH; fst/mst = stall cycles in FETCH / MEMRD|MEMWR.
  task automatic run_instr(int sel, logic [5:0] op, int fst, int mst);
    bit en, bad, bne, mem;
    int path[$];
    int s, n;
    en  = (sel == 0);
    bad = 1'b0;
    bne = (op == 6'b000101) && en;
    path = {0, 1};
    case (op)
      6'b000000: path = {0, 1, 6, 7};
      6'b100011: path = {0, 1, 2, 3, 4};
      6'b101011: path = {0, 1, 2, 5};
      6'b000100: path = {0, 1, 8};
      6'b000101: if (en) path = {0, 1, 8}; else bad = 1'b1;
      6'b001000: path = {0, 1, 9, 10};
      6'b001101: if (en) path = {0, 1, 12, 10}; else bad = 1'b1;
      6'b000010: path = {0, 1, 11};
      default:   bad = 1'b1;
    endcase
    foreach (path[i]) begin
      s   = path[i];
      mem = (s == 0 || s == 3 || s == 5);
      n   = !mem ? 0 : (s == 0 ? fst : mst);
      if (en) begin
        repeat (n) step(sel, op, 1'b0, s, bne);
        step(sel, op, 1'b1, s, bne);
      end else begin
        step(sel, op, mem ? 1'($urandom_range(0, 1)) : 1'b1, s, bne);
      end
    end
    if (bad) begin
      if (sel == 0) ill0 = 1'b1; else ill1 = 1'b1;
    end
  endtask

  task automatic rand_instr(int sel);
    logic [5:0] ops [9];
    logic [5:0] op;
    int k;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
            6'b001000, 6'b001101, 6'b000010, 6'b111111};
    k = $urandom_range(0, 9);
    op = (k == 9) ? 6'($urandom) : ops[k];
    run_instr(sel, op, $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  // Monitor: compare whatever the DUTs show against the queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0 cycle {state,ctl}", {10'd0, if0.state, act0}, {10'd0, e.st, e.sig});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1 cycle {state,ctl}", {10'd0, if1.state, act1}, {10'd0, e.st, e.sig});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    if0.op = 6'd0; if0.mem_ready = 1'b1;
    if1.op = 6'd0; if1.mem_ready = 1'b0;
    reset = 1'b0;
    // Held in reset across clock edges: FETCH values, strobes forced low.
    repeat (2) @(posedge clk);
    #1;
    check("reset state", 32'(if0.state), 32'd0);
    check("reset pcwrite", 32'(if0.pcwrite), 32'd0);
    check("reset irwrite", 32'(if0.irwrite), 32'd0);
    check("reset memwrite", 32'(if0.memwrite), 32'd0);
    check("reset illegal", 32'(if0.illegal), 32'd0);
    check("reset alusrcb", 32'(if0.alusrcb), 32'd1);
    reset = 1'b1;

    // Directed: full-featured instance.
    run_instr(0, 6'b000000, 0, 0);
    run_instr(0, 6'b100011, 0, 2);
    run_instr(0, 6'b101011, 1, 3);
    run_instr(0, 6'b000101, 0, 0);
    run_instr(0, 6'b000100, 2, 0);
    run_instr(0, 6'b001101, 0, 0);
    run_instr(0, 6'b001000, 0, 0);
    run_instr(0, 6'b000010, 0, 0);
    run_instr(0, 6'b111111, 1, 0);
    repeat (40) rand_instr(0);

    // Async reset while a store is holding memwrite.
    step(0, 6'b101011, 1'b1, 0, 1'b0);
    step(0, 6'b101011, 1'b1, 1, 1'b0);
    step(0, 6'b101011, 1'b1, 2, 1'b0);
    if0.mem_ready = 1'b0;
    #1;
    check("memwr memwrite", 32'(if0.memwrite), 32'd1);
    check("memwr illegal before reset", 32'(if0.illegal), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("async rst memwrite", 32'(if0.memwrite), 32'd0);
    check("async rst state", 32'(if0.state), 32'd0);
    check("async rst illegal", 32'(if0.illegal), 32'd0);
    check("async rst pcwrite", 32'(if0.pcwrite), 32'd0);
    ill0 = 1'b0;
    ill1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Reduced instance: BNE/ORI illegal, handshake ignored. dut0 idles in FETCH.
    run_instr(1, 6'b000101, 0, 0);
    run_instr(1, 6'b000100, 0, 0);
    run_instr(1, 6'b001101, 0, 0);
    run_instr(1, 6'b100011, 0, 0);
    run_instr(1, 6'b101011, 0, 0);
    run_instr(1, 6'b000000, 0, 0);
    run_instr(1, 6'b000010, 0, 0);
    repeat (30) rand_instr(1);

    @(posedge clk); #1;
    check("dut0 idle in fetch", 32'(if0.state), 32'd0);
    check("queues drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
